// File: rtl/nibble_add_arbiter.sv
// Round-robin arbiter in front of one shared registered W-bit adder.
// Sequence per operation: IDLE (grant + capture) -> EXEC (add) -> RESP (hold until taken).
module nibble_add_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*W-1:0]        req_a,
  input  logic [NREQ*W-1:0]        req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [W-1:0]             rsp_sum,
  output logic                     rsp_carry,
  output logic                     busy,
  output logic [7:0]               op_count
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           carry_q, carry_d;
  logic [7:0]     op_count_q, op_count_d;

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] scan_idx;
  logic           accept;

  // Scan starting at rr_ptr; NREQ is a power of two so the index wraps by truncation.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = rr_ptr_q + IDW'(k);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_found) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
    rsp_valid = (state_q == RESP);
    busy      = (state_q != IDLE);
  end

  assign accept = (state_q == IDLE) && grant_found;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_id_d   = rsp_id_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    op_count_d = op_count_q;
    if (accept) begin
      a_d      = req_a[grant_idx*W +: W];
      b_d      = req_b[grant_idx*W +: W];
      id_d     = grant_idx;
      rr_ptr_d = grant_idx + IDW'(1);
    end
    if (state_q == EXEC) begin
      {carry_d, sum_d} = {1'b0, a_q} + {1'b0, b_q};
      rsp_id_d         = id_q;
    end
    if (state_q == RESP && rsp_ready) begin
      op_count_d = op_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      id_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_id_q   <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      op_count_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_id_q   <= rsp_id_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      op_count_q <= op_count_d;
    end
  end

  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = sum_q;
  assign rsp_carry = carry_q;
  assign op_count  = op_count_q;

endmodule
